// File: rtl/flag_pkg.sv
// rtl/flag_pkg.sv - shared flag word type and bit indices for the conditional-execution flag bus
// Flag word order {LT, GT, EQ, Z}; indices match the validator select codes.
package flag_pkg;

    typedef logic [3:0] flag_t;

    localparam int unsigned FLAG_Z  = 0;
    localparam int unsigned FLAG_EQ = 1;
    localparam int unsigned FLAG_GT = 2;
    localparam int unsigned FLAG_LT = 3;

endpackage

// File: rtl/flag_unit_if.sv
// rtl/flag_unit_if.sv - flag unit control/data bundle with driver and flag-unit modports
// master: ALU/control side driving operands and stack commands, reading flags/status.
// slave : flag unit receiving operands and commands, driving flags/status.
interface flag_unit_if #(
    parameter int DATA_WIDTH = 16
);
    import flag_pkg::*;

    logic                  update_en;
    logic [DATA_WIDTH-1:0] result;
    logic [DATA_WIDTH-1:0] operand_a;
    logic [DATA_WIDTH-1:0] operand_b;
    logic                  signed_cmp;
    logic                  flag_load_en;
    flag_t                 flag_load;
    logic                  push;
    logic                  pop;
    logic                  error_clr;
    logic                  zero_flag;
    logic                  equal_flag;
    logic                  greater_than_flag;
    logic                  less_than_flag;
    logic                  stack_empty;
    logic                  stack_full;
    logic                  stack_error;

    modport master (
        output update_en, result, operand_a, operand_b, signed_cmp,
               flag_load_en, flag_load, push, pop, error_clr,
        input  zero_flag, equal_flag, greater_than_flag, less_than_flag,
               stack_empty, stack_full, stack_error
    );

    modport slave (
        input  update_en, result, operand_a, operand_b, signed_cmp,
               flag_load_en, flag_load, push, pop, error_clr,
        output zero_flag, equal_flag, greater_than_flag, less_than_flag,
               stack_empty, stack_full, stack_error
    );

endinterface

// File: rtl/flag_stack.sv
// rtl/flag_stack.sv - LIFO of flag words for interrupt/call save and restore
// Ports: clk, rst_n (async active-low); push, pop, wr_data (flags to save), error_clr;
//        top_data (entry at top of stack), pop_ok (pop accepted this cycle),
//        full, empty (decoded from registered pointer), error (sticky).
module flag_stack
    import flag_pkg::*;
#(
    parameter int STACK_DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  logic  pop,
    input  flag_t wr_data,
    input  logic  error_clr,
    output flag_t top_data,
    output logic  pop_ok,
    output logic  full,
    output logic  empty,
    output logic  error
);

    localparam int ADDR_W = $clog2(STACK_DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam logic [PTR_W-1:0]  DEPTH_P  = PTR_W'(STACK_DEPTH);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    flag_t            mem [STACK_DEPTH];
    logic [PTR_W-1:0] ptr;
    logic             push_ok;
    logic             err_event;

    assign full  = (ptr == DEPTH_P);
    assign empty = (ptr == '0);

    // A simultaneous push and pop is treated as an error, so neither is accepted.
    assign push_ok   = push && !pop && !full;
    assign pop_ok    = pop && !push && !empty;
    assign err_event = (push && pop) || (push && !pop && full) || (pop && !push && empty);

    // When empty this index wraps, but pop_ok is low so the value is never used.
    assign top_data = mem[ptr[ADDR_W-1:0] - ADDR_ONE];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (push_ok) begin
            ptr <= ptr + PTR_ONE;
        end else if (pop_ok) begin
            ptr <= ptr - PTR_ONE;
        end
    end

    // Storage has no reset: contents below the pointer are the only ones ever read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[ptr[ADDR_W-1:0]] <= wr_data;
        end
    end

    // A new error in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error <= 1'b0;
        end else if (err_event) begin
            error <= 1'b1;
        end else if (error_clr) begin
            error <= 1'b0;
        end
    end

endmodule

// File: rtl/flag_unit.sv
// rtl/flag_unit.sv - flag producer: compare logic, architectural flag register, flag stack
// Ports: clk, rst_n (async active-low); bus (flag_unit_if.slave) carrying operands,
//        update/load/push/pop/error_clr commands and the registered flag/stack status.
module flag_unit
    import flag_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    flag_unit_if.slave     bus
);

    flag_t flags_q;
    flag_t flags_calc;
    flag_t flags_next;
    flag_t stack_top;
    logic  pop_ok;

    always_comb begin
        flags_calc          = '0;
        flags_calc[FLAG_Z]  = (bus.result == '0);
        flags_calc[FLAG_EQ] = (bus.operand_a == bus.operand_b);
        if (bus.signed_cmp) begin
            flags_calc[FLAG_GT] = ($signed(bus.operand_a) > $signed(bus.operand_b));
            flags_calc[FLAG_LT] = ($signed(bus.operand_a) < $signed(bus.operand_b));
        end else begin
            flags_calc[FLAG_GT] = (bus.operand_a > bus.operand_b);
            flags_calc[FLAG_LT] = (bus.operand_a < bus.operand_b);
        end
    end

    // Accepted pop restores saved flags and overrides load/update; a rejected pop
    // falls through as if it were not requested.
    always_comb begin
        flags_next = flags_q;
        if (pop_ok) begin
            flags_next = stack_top;
        end else if (bus.flag_load_en) begin
            flags_next = bus.flag_load;
        end else if (bus.update_en) begin
            flags_next = flags_calc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_next;
        end
    end

    // The stack always saves the pre-edge register, so push with load/update
    // stores the old flags while the register takes the new ones.
    flag_stack #(
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (bus.push),
        .pop       (bus.pop),
        .wr_data   (flags_q),
        .error_clr (bus.error_clr),
        .top_data  (stack_top),
        .pop_ok    (pop_ok),
        .full      (bus.stack_full),
        .empty     (bus.stack_empty),
        .error     (bus.stack_error)
    );

    assign bus.zero_flag         = flags_q[FLAG_Z];
    assign bus.equal_flag        = flags_q[FLAG_EQ];
    assign bus.greater_than_flag = flags_q[FLAG_GT];
    assign bus.less_than_flag    = flags_q[FLAG_LT];

endmodule

// File: tb/tb_flag_unit.sv
// tb/tb_flag_unit.sv - directed self-checking bench for flag_unit
module tb_flag_unit;
    import flag_pkg::*;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    flag_unit_if #(.DATA_WIDTH(16)) bus ();

    flag_unit #(
        .DATA_WIDTH  (16),
        .STACK_DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic flag_t cur_flags();
        return {bus.less_than_flag, bus.greater_than_flag, bus.equal_flag, bus.zero_flag};
    endfunction

    function automatic logic [2:0] cur_status();
        return {bus.stack_error, bus.stack_full, bus.stack_empty};
    endfunction

    task automatic idle_inputs();
        bus.update_en    = 1'b0;
        bus.result       = '0;
        bus.operand_a    = '0;
        bus.operand_b    = '0;
        bus.signed_cmp   = 1'b0;
        bus.flag_load_en = 1'b0;
        bus.flag_load    = '0;
        bus.push         = 1'b0;
        bus.pop          = 1'b0;
        bus.error_clr    = 1'b0;
    endtask

    // Apply current inputs across one rising edge, return 1 time unit after it, then idle.
    task automatic step();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #3;
        vectors++;
        if (cur_flags() !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags got=%b exp=%b", cur_flags(), 4'b0000);
        end
        vectors++;
        if (cur_status() !== 3'b001) begin
            miscompares++;
            $display("FAIL reset_status {err,full,empty} got=%b exp=%b", cur_status(), 3'b001);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_update();
        bus.update_en = 1'b1; bus.result = 16'd0; bus.operand_a = 16'd5; bus.operand_b = 16'd5;
        step();
        vectors++;
        if (cur_flags() !== 4'b0011) begin
            miscompares++;
            $display("FAIL update_eq_zero got=%b exp=%b", cur_flags(), 4'b0011);
        end
        vectors++;
        if (cur_status() !== 3'b001) begin
            miscompares++;
            $display("FAIL update_status got=%b exp=%b", cur_status(), 3'b001);
        end
        bus.update_en = 1'b1; bus.result = 16'd3; bus.operand_a = 16'hFFFF; bus.operand_b = 16'd1;
        bus.signed_cmp = 1'b1;
        step();
        vectors++;
        if (cur_flags() !== 4'b1000) begin
            miscompares++;
            $display("FAIL update_signed_lt got=%b exp=%b", cur_flags(), 4'b1000);
        end
        bus.update_en = 1'b1; bus.result = 16'd3; bus.operand_a = 16'hFFFF; bus.operand_b = 16'd1;
        bus.signed_cmp = 1'b0;
        step();
        vectors++;
        if (cur_flags() !== 4'b0100) begin
            miscompares++;
            $display("FAIL update_unsigned_gt got=%b exp=%b", cur_flags(), 4'b0100);
        end
        // Hold: no write enables, register keeps its value.
        step();
        vectors++;
        if (cur_flags() !== 4'b0100) begin
            miscompares++;
            $display("FAIL hold got=%b exp=%b", cur_flags(), 4'b0100);
        end
        // Load beats update in the same cycle.
        bus.flag_load_en = 1'b1; bus.flag_load = 4'b1001;
        bus.update_en = 1'b1; bus.operand_a = 16'd1; bus.operand_b = 16'd1;
        step();
        vectors++;
        if (cur_flags() !== 4'b1001) begin
            miscompares++;
            $display("FAIL load_over_update got=%b exp=%b", cur_flags(), 4'b1001);
        end
    endtask

    task automatic test_load_push_pop();
        bus.flag_load_en = 1'b1; bus.flag_load = 4'b0100;
        step();
        bus.push = 1'b1; bus.update_en = 1'b1; bus.result = 16'd7;
        bus.operand_a = 16'd2; bus.operand_b = 16'd9;
        step();
        vectors++;
        if (cur_flags() !== 4'b1000) begin
            miscompares++;
            $display("FAIL push_update_reg got=%b exp=%b", cur_flags(), 4'b1000);
        end
        vectors++;
        if (cur_status() !== 3'b000) begin
            miscompares++;
            $display("FAIL push_status got=%b exp=%b", cur_status(), 3'b000);
        end
        // Pop wins over a same-cycle update.
        bus.pop = 1'b1; bus.update_en = 1'b1; bus.operand_a = 16'd9; bus.operand_b = 16'd9;
        step();
        vectors++;
        if (cur_flags() !== 4'b0100) begin
            miscompares++;
            $display("FAIL pop_restore got=%b exp=%b", cur_flags(), 4'b0100);
        end
        vectors++;
        if (cur_status() !== 3'b001) begin
            miscompares++;
            $display("FAIL pop_status got=%b exp=%b", cur_status(), 3'b001);
        end
    endtask

    task automatic test_full_empty();
        flag_t vals [6];
        vals = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1010, 4'b0101};
        bus.flag_load_en = 1'b1; bus.flag_load = vals[0];
        step();
        for (int i = 1; i <= 4; i++) begin
            bus.push = 1'b1; bus.flag_load_en = 1'b1; bus.flag_load = vals[i];
            step();
        end
        vectors++;
        if (cur_status() !== 3'b010) begin
            miscompares++;
            $display("FAIL four_push_full got=%b exp=%b", cur_status(), 3'b010);
        end
        bus.push = 1'b1; bus.flag_load_en = 1'b1; bus.flag_load = vals[5];
        step();
        vectors++;
        if (cur_status() !== 3'b110) begin
            miscompares++;
            $display("FAIL overflow_status got=%b exp=%b", cur_status(), 3'b110);
        end
        vectors++;
        if (cur_flags() !== vals[5]) begin
            miscompares++;
            $display("FAIL overflow_reg_load got=%b exp=%b", cur_flags(), vals[5]);
        end
        for (int i = 3; i >= 0; i--) begin
            bus.pop = 1'b1;
            step();
            vectors++;
            if (cur_flags() !== vals[i]) begin
                miscompares++;
                $display("FAIL pop_order_%0d got=%b exp=%b", i, cur_flags(), vals[i]);
            end
        end
        vectors++;
        if (cur_status() !== 3'b101) begin
            miscompares++;
            $display("FAIL drained_status got=%b exp=%b", cur_status(), 3'b101);
        end
        bus.pop = 1'b1;
        step();
        vectors++;
        if (cur_flags() !== vals[0]) begin
            miscompares++;
            $display("FAIL underflow_flags got=%b exp=%b", cur_flags(), vals[0]);
        end
        vectors++;
        if (cur_status() !== 3'b101) begin
            miscompares++;
            $display("FAIL underflow_status got=%b exp=%b", cur_status(), 3'b101);
        end
        // Rejected pop lets a same-cycle load through.
        bus.pop = 1'b1; bus.flag_load_en = 1'b1; bus.flag_load = 4'b1100;
        step();
        vectors++;
        if (cur_flags() !== 4'b1100) begin
            miscompares++;
            $display("FAIL underflow_load got=%b exp=%b", cur_flags(), 4'b1100);
        end
        bus.error_clr = 1'b1;
        step();
        vectors++;
        if (cur_status() !== 3'b001) begin
            miscompares++;
            $display("FAIL error_clr got=%b exp=%b", cur_status(), 3'b001);
        end
    endtask

    task automatic test_collision();
        bus.flag_load_en = 1'b1; bus.flag_load = 4'b0011;
        step();
        bus.push = 1'b1;
        step();
        bus.push = 1'b1; bus.pop = 1'b1; bus.flag_load_en = 1'b1; bus.flag_load = 4'b0110;
        step();
        vectors++;
        if (cur_flags() !== 4'b0110) begin
            miscompares++;
            $display("FAIL collision_reg got=%b exp=%b", cur_flags(), 4'b0110);
        end
        vectors++;
        if (cur_status() !== 3'b100) begin
            miscompares++;
            $display("FAIL collision_status got=%b exp=%b", cur_status(), 3'b100);
        end
        // Exactly one entry must remain.
        bus.pop = 1'b1;
        step();
        vectors++;
        if (cur_flags() !== 4'b0011 || cur_status() !== 3'b101) begin
            miscompares++;
            $display("FAIL collision_count flags=%b status=%b exp flags=%b status=%b",
                     cur_flags(), cur_status(), 4'b0011, 3'b101);
        end
        bus.error_clr = 1'b1;
        step();
        bus.error_clr = 1'b1; bus.pop = 1'b1;
        step();
        vectors++;
        if (bus.stack_error !== 1'b1) begin
            miscompares++;
            $display("FAIL clr_vs_set got=%b exp=%b", bus.stack_error, 1'b1);
        end
        bus.error_clr = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        bus.flag_load_en = 1'b1; bus.flag_load = 4'b1001;
        step();
        bus.push = 1'b1; bus.flag_load_en = 1'b1; bus.flag_load = 4'b0110;
        step();
        bus.pop = 1'b1;
        step();
        vectors++;
        if (cur_flags() !== 4'b1001) begin
            miscompares++;
            $display("FAIL b2b_pop1 got=%b exp=%b", cur_flags(), 4'b1001);
        end
        bus.push = 1'b1; bus.flag_load_en = 1'b1; bus.flag_load = 4'b0000;
        step();
        bus.pop = 1'b1;
        step();
        vectors++;
        if (cur_flags() !== 4'b1001 || cur_status() !== 3'b001) begin
            miscompares++;
            $display("FAIL b2b_pop2 flags=%b status=%b exp flags=%b status=%b",
                     cur_flags(), cur_status(), 4'b1001, 3'b001);
        end
    endtask

    task automatic test_reset_mid();
        bus.flag_load_en = 1'b1; bus.flag_load = 4'b0101;
        step();
        bus.push = 1'b1;
        step();
        bus.push = 1'b1;
        step();
        bus.push = 1'b1; bus.pop = 1'b1;
        step();
        bus.push = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (cur_flags() !== 4'b0000) begin
            miscompares++;
            $display("FAIL midreset_flags got=%b exp=%b", cur_flags(), 4'b0000);
        end
        vectors++;
        if (cur_status() !== 3'b001) begin
            miscompares++;
            $display("FAIL midreset_status got=%b exp=%b", cur_status(), 3'b001);
        end
        idle_inputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.pop = 1'b1;
        step();
        vectors++;
        if (cur_flags() !== 4'b0000 || cur_status() !== 3'b101) begin
            miscompares++;
            $display("FAIL postreset_pop flags=%b status=%b exp flags=%b status=%b",
                     cur_flags(), cur_status(), 4'b0000, 3'b101);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_update();
        test_load_push_pop();
        test_full_empty();
        test_collision();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/flag_unit.md
# flag_unit

Producer side of the conditional-execution flag bus: computes ZERO, EQUAL, GREATER_THAN and LESS_THAN from ALU result and comparison operands, holds them in an architectural flag register, and drives them to the flag validator used by branch/conditional logic. Includes a small LIFO flag stack so interrupt entry/exit and call/return can save and restore flags. Sits between the ALU output stage and the control unit.

## Interface
Parameters:
- DATA_WIDTH, 16, width of RESULT and the comparison operands.
- STACK_DEPTH, 4, number of saved flag words; a power of two, at least 2.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RST_N  in  1  reset; asynchronous, active-low.
- UPDATE_EN  in  1  capture flags computed from RESULT/OPERAND_A/OPERAND_B this cycle.
- RESULT  in  DATA_WIDTH  ALU result; source of ZERO.
- OPERAND_A  in  DATA_WIDTH  compare left operand.
- OPERAND_B  in  DATA_WIDTH  compare right operand.
- SIGNED_CMP  in  1  1 = two's-complement compare, 0 = unsigned.
- FLAG_LOAD_EN  in  1  overwrite flag register with FLAG_LOAD.
- FLAG_LOAD  in  4  direct flag value, order {LT, GT, EQ, Z}.
- PUSH  in  1  save current flag register onto the stack.
- POP  in  1  restore flag register from top of the stack.
- ERROR_CLR  in  1  clear STACK_ERROR.
- ZERO_FLAG  out  1  registered Z.
- EQUAL_FLAG  out  1  registered EQ.
- GREATER_THAN_FLAG  out  1  registered GT.
- LESS_THAN_FLAG  out  1  registered LT.
- STACK_EMPTY  out  1  stack holds 0 entries.
- STACK_FULL  out  1  stack holds STACK_DEPTH entries.
- STACK_ERROR  out  1  sticky: overflow, underflow, or PUSH+POP collision.

## Operation
- Flag word bit order {LT, GT, EQ, Z} = indices 3..0, matching validator select codes 3..0.
- UPDATE_EN: Z = (RESULT == 0); EQ = (A == B); GT = A > B; LT = A < B, signed or unsigned per SIGNED_CMP. After any UPDATE, exactly one of EQ/GT/LT is 1.
- Flag-register write priority in one cycle: valid POP > FLAG_LOAD_EN > UPDATE_EN; otherwise hold.
- PUSH (stack not full, no POP): writes pre-edge flag register into stack[ptr], ptr+1. Combinable with UPDATE_EN/FLAG_LOAD_EN: stack gets old flags, register gets new ones.
- POP (stack not empty, no PUSH): flag register <= stack[ptr-1], ptr-1; UPDATE_EN/FLAG_LOAD_EN same cycle ignored.
- PUSH when full: stack unchanged, STACK_ERROR <= 1; flag register still follows FLAG_LOAD_EN/UPDATE_EN.
- POP when empty: flag register follows FLAG_LOAD_EN/UPDATE_EN as if no POP; STACK_ERROR <= 1.
- PUSH and POP same cycle: no stack change, STACK_ERROR <= 1; flag register follows FLAG_LOAD_EN/UPDATE_EN.
- STACK_ERROR: set by any error above, cleared by ERROR_CLR; set wins if both same cycle.
- Pointer width clog2(STACK_DEPTH)+1; never wraps (overflow/underflow blocked).

## Timing
- Reset (RST_N low, immediate): all four flags 0, pointer 0, STACK_EMPTY 1, STACK_FULL 0, STACK_ERROR 0. Stack contents undefined, never observable (pop-when-empty blocked).
- Reset deasserted mid-operation: state restarts from reset values; no partial push survives.
- Latency: inputs sampled at edge N, flags/status valid after edge N (1 cycle). Outputs purely registered, no combinational input-to-output path.
- STACK_EMPTY/STACK_FULL decoded from registered pointer; update same edge as the push/pop.
- Back-to-back PUSH/POP every cycle supported; no stall, no handshake.

## Structure
- Shared package flag_pkg: flag_t (4-bit), index constants FLAG_Z=0, FLAG_EQ=1, FLAG_GT=2, FLAG_LT=3; also imported by the validator and control decoder.
- Sub-module flag_stack: LIFO of flag_t with push/pop/full/empty/error outputs, parameterised by STACK_DEPTH. Top level holds compare logic, flag register, priority mux.

## Test plan
- Reset, then UPDATE_EN with RESULT=0, A=5, B=5 -> next cycle Z=1, EQ=1, GT=0, LT=0; EMPTY=1.
- SIGNED_CMP=1, A=16'hFFFF, B=1, RESULT=3 -> LT=1, Z=0; same with SIGNED_CMP=0 -> GT=1.
- FLAG_LOAD 4'b0100 then PUSH with UPDATE_EN (A=2, B=9) -> register LT=1; POP -> flags {0,1,0,0} restored, EMPTY=1.
- Four PUSHes (DEPTH=4) -> FULL=1; fifth PUSH -> ERROR=1, pointer unchanged; four POPs return values in reverse order; fifth POP -> flags unchanged, ERROR stays 1 until ERROR_CLR.
- PUSH+POP same cycle with one entry stored -> entry count still 1, ERROR=1; ERROR_CLR + new error same cycle -> ERROR stays 1.
- Assert RST_N low during a PUSH cycle with two entries stored -> immediately flags 0, EMPTY=1, FULL=0, ERROR=0.
